fpu_add_seq: RTL and testbench

- Multicycle sequencer for single-precision (IEEE-754 binary32) add/subtract in the multicycle ARM FPU path.
- Replaces the single-cycle adder, which ignores signs and normalises only on carry-out. It runs one pass as align, add, then iterative normalise, under a start/done handshake.
- The main control FSM issues start, stalls on busy and writes result back when done pulses.

---
 rtl/fpu_add_seq.sv | 184 ++++++++++++++++++
 tb/tb_fpu_add_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_seq.sv
// Multicycle binary32 add/subtract sequencer.
// Align, add, then iterative normalise under a start/done handshake.
module fpu_add_seq #(
  parameter bit SPECIAL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  st_q, st_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sub_q, sub_d;
  logic [23:0] big_q, big_d;
  logic [24:0] sml_q, sml_d;
  logic [8:0]  exp_q, exp_d;
  logic        sgn_q, sgn_d;
  logic        dif_q, dif_d;
  logic [24:0] mant_q, mant_d;
  logic [31:0] res_q, res_d;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        sa, sb;
  logic [23:0] ma, mb;
  logic        a_inf, b_inf;
  logic        a_nan, b_nan;
  logic        spec, zz, a_big;
  logic [7:0]  dexp;
  logic [23:0] msml;
  logic [31:0] spec_res;
  logic [8:0]  exp_inc;

  // Operand decode for the ALIGN step.
  always_comb begin
    ea    = a_q[30:23];
    eb    = b_q[30:23];
    fa    = a_q[22:0];
    fb    = b_q[22:0];
    sa    = a_q[31];
    sb    = b_q[31] ^ sub_q;
    ma    = (ea == 8'd0) ? 24'd0 : {1'b1, fa};
    mb    = (eb == 8'd0) ? 24'd0 : {1'b1, fb};
    a_inf = SPECIAL_EN && (ea == 8'hFF) && (fa == 23'd0);
    b_inf = SPECIAL_EN && (eb == 8'hFF) && (fb == 23'd0);
    a_nan = SPECIAL_EN && (ea == 8'hFF) && (fa != 23'd0);
    b_nan = SPECIAL_EN && (eb == 8'hFF) && (fb != 23'd0);
    spec  = SPECIAL_EN && ((ea == 8'hFF) || (eb == 8'hFF));
    zz    = (ea == 8'd0) && (eb == 8'd0);
    a_big = {ea, fa} >= {eb, fb};
    dexp  = a_big ? (ea - eb) : (eb - ea);
    msml  = a_big ? mb : ma;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      spec_res = 32'h7FC0_0000;
    else if (a_inf)
      spec_res = {sa, 8'hFF, 23'd0};
    else
      spec_res = {sb, 8'hFF, 23'd0};
    exp_inc = exp_q + 9'd1;
  end

  // Next-state and datapath update per FSM state.
  always_comb begin
    st_d   = st_q;
    a_d    = a_q;
    b_d    = b_q;
    sub_d  = sub_q;
    big_d  = big_q;
    sml_d  = sml_q;
    exp_d  = exp_q;
    sgn_d  = sgn_q;
    dif_d  = dif_q;
    mant_d = mant_q;
    res_d  = res_q;
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          a_d   = op_a;
          b_d   = op_b;
          sub_d = sub;
          st_d  = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (spec) begin
          res_d = spec_res;
          st_d  = S_DONE;
        end else if (zz) begin
          res_d = (sa && sb) ? 32'h8000_0000 : 32'h0;
          st_d  = S_DONE;
        end else begin
          big_d = a_big ? ma : mb;
          if (dexp >= 8'd25)
            sml_d = 25'd0;
          else
            sml_d = {1'b0, msml} >> dexp;
          exp_d = {1'b0, (a_big ? ea : eb)};
          sgn_d = a_big ? sa : sb;
          dif_d = sa ^ sb;
          st_d  = S_ADD;
        end
      end
      S_ADD: begin
        if (dif_q)
          mant_d = {1'b0, big_q} - sml_q;
        else
          mant_d = {1'b0, big_q} + sml_q;
        st_d = S_NORM;
      end
      S_NORM: begin
        if (mant_q == 25'd0) begin
          res_d = 32'h0;
          st_d  = S_DONE;
        end else if (mant_q[24]) begin
          if (exp_inc == 9'd255)
            res_d = {sgn_q, 8'hFF, 23'd0};
          else
            res_d = {sgn_q, exp_inc[7:0], mant_q[23:1]};
          st_d = S_DONE;
        end else if (!mant_q[23]) begin
          if (exp_q <= 9'd1) begin
            res_d = {sgn_q, 31'd0};
            st_d  = S_DONE;
          end else begin
            mant_d = mant_q << 1;
            exp_d  = exp_q - 9'd1;
          end
        end else begin
          res_d = {sgn_q, exp_q[7:0], mant_q[22:0]};
          st_d  = S_DONE;
        end
      end
      S_DONE: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      big_q  <= '0;
      sml_q  <= '0;
      exp_q  <= '0;
      sgn_q  <= 1'b0;
      dif_q  <= 1'b0;
      mant_q <= '0;
      res_q  <= '0;
    end else begin
      st_q   <= st_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sub_q  <= sub_d;
      big_q  <= big_d;
      sml_q  <= sml_d;
      exp_q  <= exp_d;
      sgn_q  <= sgn_d;
      dif_q  <= dif_d;
      mant_q <= mant_d;
      res_q  <= res_d;
    end
  end

  assign busy   = (st_q != S_IDLE);
  assign done   = (st_q == S_DONE);
  assign result = res_q;

endmodule

// File: tb/tb_fpu_add_seq.sv
// Testbench for fpu_add_seq.
// Directed cases plus random operands against an arithmetic model.
module tb_fpu_add_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;
  int ndone = 0;

  fpu_add_seq #(.SPECIAL_EN(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) ndone <= ndone + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value-level reference: returns result and edges-to-done count.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       input bit s, output logic [31:0] r,
                       output int n);
    int ea, eb, fa, fb, va, vb, big, sml, d, m, e;
    bit sa, sb, sg, nan, uf;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = int'(a[22:0]);  fb = int'(b[22:0]);
    sa = a[31];          sb = b[31] ^ s;
    n = 2;
    if (ea == 255 || eb == 255) begin
      nan = (ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
            (ea == 255 && eb == 255 && sa != sb);
      if (nan) r = 32'h7FC0_0000;
      else if (ea == 255) r = {sa, 8'hFF, 23'd0};
      else r = {sb, 8'hFF, 23'd0};
      return;
    end
    if (ea == 0 && eb == 0) begin
      r = (sa && sb) ? 32'h8000_0000 : 32'h0;
      return;
    end
    va = (ea == 0) ? 0 : (fa + (1 << 23));
    vb = (eb == 0) ? 0 : (fb + (1 << 23));
    if (ea > eb || (ea == eb && fa >= fb)) begin
      big = va; sml = vb; d = ea - eb; e = ea; sg = sa;
    end else begin
      big = vb; sml = va; d = eb - ea; e = eb; sg = sb;
    end
    sml = (d >= 25) ? 0 : (sml >> d);
    m = (sa == sb) ? big + sml : big - sml;
    n = 4;
    if (m == 0) begin
      r = 32'h0;
    end else if (m >= (1 << 24)) begin
      m = m / 2;
      e = e + 1;
      if (e == 255) r = {sg, 8'hFF, 23'd0};
      else r = {sg, e[7:0], m[22:0]};
    end else begin
      uf = 1'b0;
      while (m < (1 << 23) && !uf) begin
        if (e <= 1) uf = 1'b1;
        else begin
          m = m * 2;
          e = e - 1;
          n++;
        end
      end
      if (uf) r = {sg, 31'd0};
      else r = {sg, e[7:0], m[22:0]};
    end
  endtask

  // Issue one operation and check latency, result and handshake.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit s, input logic [31:0] er,
                        input int en, input bit poke);
    int n;
    int d0;
    d0 = ndone;
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check("busy", {31'd0, busy}, 32'd1);
    while (!done && n < 100) begin
      if (poke && n == 2) begin
        start = 1'b1;
        op_a = $urandom; op_b = $urandom; sub = ~s;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("latency", n, en);
    check("result", result, er);
    @(posedge clk); #1;
    check("idle", {30'd0, busy, done}, 32'd0);
    check("ndone", ndone - d0, 32'd1);
  endtask

  function automatic logic [31:0] rnd_op(input int e0);
    int k;
    int e;
    logic [31:0] v;
    k = $urandom_range(0, 19);
    v = $urandom;
    if (k == 0) v[30:23] = 8'd0;
    else if (k == 1) v[30:0] = {8'hFF, 23'd0};
    else if (k == 2) v[30:23] = 8'hFF;
    else begin
      e = e0 + $urandom_range(0, 8) - 4;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
      v[30:23] = e[7:0];
      if (k < 6) v[22:0] = v[22:0] & 23'h7F_0000;
    end
    return v;
  endfunction

  initial begin
    logic [31:0] ra, rb, er;
    int en;
    int e0;
    int d0;
    bit s;
    reset = 1'b0;
    start = 1'b1;
    sub = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst", {30'd0, busy, done}, 32'd0);
    end

    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4, 1'b0);
    run_op(32'h4000_0000, 32'h3F00_0000, 1'b0, 32'h4020_0000, 4, 1'b0);
    run_op(32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 5, 1'b0);
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4, 1'b0);
    run_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 2, 1'b0);
    run_op(32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 2, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 2, 1'b0);
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4, 1'b0);
    run_op(32'h4B80_0000, 32'h3F80_0000, 1'b0, 32'h4B80_0000, 4, 1'b0);
    run_op(32'h8080_0001, 32'h8080_0000, 1'b1, 32'h8000_0000, 4, 1'b0);
    run_op(32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, 27, 1'b1);

    repeat (20) @(posedge clk);
    #1;
    check("no_extra_done", {31'd0, done}, 32'd0);
    check("held_result", result, 32'h3400_0000);

    op_a = 32'h3F80_0001; op_b = 32'h3F80_0000; sub = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    d0 = ndone;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("abort_ndone", ndone - d0, 32'd0);
    check("abort_idle", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: e0 = $urandom_range(1, 5);
        1: e0 = $urandom_range(248, 254);
        default: e0 = $urandom_range(100, 150);
      endcase
      ra = rnd_op(e0);
      rb = rnd_op(e0);
      s = 1'($urandom_range(0, 1));
      model(ra, rb, s, er, en);
      run_op(ra, rb, s, er, en, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
